// File: rtl/opc_wait_mem.sv
// Single-port word memory for OPC-family cores: req/ack handshake with a
// programmable wait-state FSM, sticky range-error/halt flags and access counters.
module opc_wait_mem #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 2048,
    parameter int WAIT_STATES = 0,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              req,
    input  logic              rnw,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic              err,
    input  logic              halt,
    output logic              halted,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Range compare is done one bit wider than either operand so DEPTH == 2^ADDR_W fits.
    localparam int CMP_W = ((ADDR_W > IDX_W) ? ADDR_W : IDX_W) + 1;
    localparam logic [CMP_W-1:0] DEPTH_C = CMP_W'(DEPTH);
    localparam logic [3:0]       WAIT_C  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

    typedef struct packed {
        logic              rnw;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t            state, state_nxt;
    req_t              cap;
    logic [3:0]        wcnt;
    logic              accept;
    logic              in_range;
    logic              do_access;
    logic              do_wr;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] mem [DEPTH];

    assign accept    = (state == IDLE) && req && !halted;
    assign do_access = (state == ACCESS);
    assign in_range  = CMP_W'(cap.address) < DEPTH_C;
    assign idx       = IDX_W'(cap.address);
    // Reset wins over a completing write so an aborted access leaves memory untouched.
    assign do_wr     = do_access && !cap.rnw && in_range && reset_b;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_b) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (WAIT_STATES == 0) ? ACCESS : WAIT;
            WAIT:    if (wcnt == 4'd1) state_nxt = ACCESS;
            ACCESS:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            cap  <= '0;
            wcnt <= '0;
        end else if (accept) begin
            cap.rnw     <= rnw;
            cap.address <= address;
            cap.wdata   <= wdata;
            wcnt        <= WAIT_C;
        end else if (state == WAIT) begin
            wcnt <= wcnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[idx] <= cap.wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            rdata    <= '0;
            ack      <= 1'b0;
            err      <= 1'b0;
            halted   <= 1'b0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            ack <= do_access;
            if (halt) halted <= 1'b1;
            if (do_access) begin
                if (!in_range) err <= 1'b1;
                if (cap.rnw) begin
                    rdata <= in_range ? mem[idx] : '1;
                    if (rd_count != '1) rd_count <= rd_count + CNT_W'(1);
                end else if (wr_count != '1) begin
                    wr_count <= wr_count + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_opc_wait_mem.sv
// Bench for opc_wait_mem: three instances with different wait-state, depth and
// counter-width settings, driven by a table plus hand-written corner sequences.
module tb_opc_wait_mem;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_b [3];
    logic       req   [3];
    logic       rnw   [3];
    logic       halt  [3];
    logic [9:0] addr  [3];
    logic [7:0] wdata [3];
    logic [7:0] rdata [3];
    logic       ack   [3];
    logic       busy  [3];
    logic       err   [3];
    logic       halted[3];
    logic [1:0]  rdc0, wrc0;
    logic [15:0] rdc1, wrc1, rdc2, wrc2;

    opc_wait_mem #(.ADDR_W(10), .DATA_W(8), .DEPTH(512), .WAIT_STATES(0), .CNT_W(2)) u0 (
        .clk(clk), .reset_b(rst_b[0]), .req(req[0]), .rnw(rnw[0]), .address(addr[0]),
        .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0]), .err(err[0]),
        .halt(halt[0]), .halted(halted[0]), .rd_count(rdc0), .wr_count(wrc0));
    opc_wait_mem #(.ADDR_W(10), .DATA_W(8), .DEPTH(1024), .WAIT_STATES(3), .CNT_W(16)) u1 (
        .clk(clk), .reset_b(rst_b[1]), .req(req[1]), .rnw(rnw[1]), .address(addr[1]),
        .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1]), .err(err[1]),
        .halt(halt[1]), .halted(halted[1]), .rd_count(rdc1), .wr_count(wrc1));
    opc_wait_mem #(.ADDR_W(10), .DATA_W(8), .DEPTH(1024), .WAIT_STATES(2), .CNT_W(16)) u2 (
        .clk(clk), .reset_b(rst_b[2]), .req(req[2]), .rnw(rnw[2]), .address(addr[2]),
        .wdata(wdata[2]), .rdata(rdata[2]), .ack(ack[2]), .busy(busy[2]), .err(err[2]),
        .halt(halt[2]), .halted(halted[2]), .rd_count(rdc2), .wr_count(wrc2));

    typedef struct {
        bit         rnw;
        logic [9:0] addr;
        logic [7:0] wd;
        logic [7:0] exp_rd;
        bit         exp_err;
        logic [1:0] exp_rdc;
        logic [1:0] exp_wrc;
    } vec_t;

    typedef struct {
        int         d;
        logic [7:0] rd;
        int         lat;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 3 : 2;
    endfunction

    function automatic logic [31:0] rdc_of(input int d);
        return (d == 0) ? {30'd0, rdc0} : (d == 1) ? {16'd0, rdc1} : {16'd0, rdc2};
    endfunction

    function automatic logic [31:0] wrc_of(input int d);
        return (d == 0) ? {30'd0, wrc0} : (d == 1) ? {16'd0, wrc1} : {16'd0, wrc2};
    endfunction

    task automatic reset_checks(input int d);
        chk($sformatf("rst_rdata%0d", d), rdata[d], 0);
        chk($sformatf("rst_ack%0d", d), ack[d], 0);
        chk($sformatf("rst_busy%0d", d), busy[d], 0);
        chk($sformatf("rst_err%0d", d), err[d], 0);
        chk($sformatf("rst_halted%0d", d), halted[d], 0);
        chk($sformatf("rst_rdc%0d", d), rdc_of(d), 0);
        chk($sformatf("rst_wrc%0d", d), wrc_of(d), 0);
    endtask

    // hmode: 0 = no halt, 1 = halt alongside req, 2 = halt pulse in the first busy cycle.
    // noise: scramble req/address/data while the access is in flight.
    task automatic access(input int d, input bit r, input logic [9:0] a, input logic [7:0] wd,
                          input logic [7:0] exp_rd, input int hmode, input bit noise);
        int  k;
        int  bcnt;
        sb_t e;
        @(negedge clk);
        req[d] = 1'b1; rnw[d] = r; addr[d] = a; wdata[d] = wd;
        halt[d] = (hmode == 1);
        sb_q.push_back('{d, exp_rd, ws_of(d) + 1});
        @(negedge clk);
        req[d] = 1'b0;
        halt[d] = (hmode == 2);
        k = 0;
        bcnt = 0;
        while (ack[d] !== 1'b1 && k < 40) begin
            if (busy[d] === 1'b1) bcnt++;
            if (noise) begin
                req[d] = 1'b1; rnw[d] = 1'($urandom); addr[d] = 10'($urandom); wdata[d] = 8'($urandom);
            end
            @(negedge clk);
            k++;
            if (k == 1) halt[d] = 1'b0;
        end
        req[d] = 1'b0;
        e = sb_q.pop_front();
        chk($sformatf("latency%0d", e.d), k, e.lat);
        chk($sformatf("busy_cycles%0d", e.d), bcnt, e.lat);
        chk($sformatf("rdata%0d@%0h", e.d, a), rdata[e.d], e.rd);
        @(negedge clk);
        chk($sformatf("ack_pulse%0d", d), ack[d], 0);
    endtask

    task automatic no_accept(input int d);
        int bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack[d] !== 1'b0 || busy[d] !== 1'b0) bad++;
            req[d] = 1'b1; rnw[d] = 1'($urandom); addr[d] = 10'($urandom_range(0, 255));
        end
        @(negedge clk);
        if (ack[d] !== 1'b0 || busy[d] !== 1'b0) bad++;
        req[d] = 1'b0;
        chk($sformatf("halt_blocks%0d", d), bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        int   acks;
        logic [1:0] exp_seq[5];
        tbl[0] = '{0, 10'h010, 8'hA5, 8'h00, 0, 2'd0, 2'd1};
        tbl[1] = '{1, 10'h010, 8'h00, 8'hA5, 0, 2'd1, 2'd1};
        tbl[2] = '{0, 10'h000, 8'h3C, 8'hA5, 0, 2'd1, 2'd2};
        tbl[3] = '{0, 10'h200, 8'h77, 8'hA5, 1, 2'd1, 2'd3};
        tbl[4] = '{1, 10'h200, 8'h00, 8'hFF, 1, 2'd2, 2'd3};
        tbl[5] = '{1, 10'h000, 8'h00, 8'h3C, 1, 2'd3, 2'd3};
        tbl[6] = '{1, 10'h010, 8'h00, 8'hA5, 1, 2'd3, 2'd3};
        tbl[7] = '{0, 10'h1FF, 8'h5A, 8'hA5, 1, 2'd3, 2'd3};
        tbl[8] = '{1, 10'h1FF, 8'h00, 8'h5A, 1, 2'd3, 2'd3};
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        for (int i = 0; i < 3; i++) begin
            rst_b[i] = 1'b0; req[i] = 1'b0; rnw[i] = 1'b1; halt[i] = 1'b0;
            addr[i] = '0; wdata[i] = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) reset_checks(i);
        for (int i = 0; i < 3; i++) rst_b[i] = 1'b1;

        // Zero wait states, 512-word depth, 2-bit counters.
        for (int i = 0; i < 9; i++) begin
            access(0, tbl[i].rnw, tbl[i].addr, tbl[i].wd, tbl[i].exp_rd, 0, 0);
            chk($sformatf("err_v%0d", i), err[0], tbl[i].exp_err);
            chk($sformatf("rdc_v%0d", i), rdc0, tbl[i].exp_rdc);
            chk($sformatf("wrc_v%0d", i), wrc0, tbl[i].exp_wrc);
        end

        @(negedge clk); rst_b[0] = 1'b0;
        @(negedge clk); rst_b[0] = 1'b1;
        reset_checks(0);
        for (int i = 0; i < 5; i++) begin
            access(0, 1, 10'h010, 8'h00, 8'hA5, 0, 0);
            chk($sformatf("rdc_sat%0d", i), rdc0, exp_seq[i]);
        end
        chk("wrc_after_reads", wrc0, 0);
        chk("err_after_reset", err[0], 0);

        // Halt seen on the same edge as req: that request still completes.
        access(0, 0, 10'h011, 8'h42, 8'hA5, 1, 0);
        chk("halted_same_edge", halted[0], 1);
        chk("wrc_same_edge", wrc0, 1);
        no_accept(0);

        // Three wait states, with input noise during the wait.
        access(1, 0, 10'h005, 8'h22, 8'h00, 0, 0);
        access(1, 0, 10'h3FF, 8'h5C, 8'h00, 0, 0);
        access(1, 1, 10'h3FF, 8'h00, 8'h5C, 0, 1);
        chk("err_ws3", err[1], 0);
        chk("rdc_ws3", rdc1, 1);
        chk("wrc_ws3", wrc1, 2);

        // Reset during the wait of a write aborts it.
        @(negedge clk);
        req[1] = 1'b1; rnw[1] = 1'b0; addr[1] = 10'h005; wdata[1] = 8'h11;
        @(negedge clk);
        req[1] = 1'b0;
        chk("busy_before_abort", busy[1], 1);
        rst_b[1] = 1'b0;
        @(negedge clk);
        rst_b[1] = 1'b1;
        reset_checks(1);
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack[1] === 1'b1) acks++;
        end
        chk("no_ack_after_abort", acks, 0);
        access(1, 1, 10'h005, 8'h00, 8'h22, 0, 0);

        // Halt pulse while an access waits: it still completes, then nothing more.
        access(2, 0, 10'h020, 8'h99, 8'h00, 2, 0);
        chk("wrc_halt_ws2", wrc2, 1);
        chk("halted_ws2", halted[2], 1);
        no_accept(2);
        chk("wrc_after_halt", wrc2, 1);
        chk("rdc_after_halt", rdc2, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
